// File: rtl/alu_multicycle.sv
// alu_multicycle -- RV32I execute-stage ALU with an iterative shifter.
//
// add/sub/and/or/slt and the illegal code finish at the accept edge, so
// done is seen one cycle after acceptance. sll/srl with a nonzero shift
// amount move one bit per cycle in SHIFT. A shift amount of zero finishes
// at the accept edge like the other single-cycle ops.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        request, accepted only while ready
//   ALU_control  000 add, 001 sub, 010 and, 011 or, 101 slt,
//                100 sll, 110 srl, 111 illegal
//   src_a        operand A
//   src_b        operand B; [4:0] is the shift amount
//   ready        high in IDLE
//   done         one-cycle pulse; result/zero/illegal updated
//   result       registered result, held until the next done
//   zero         registered (result == 0)
//   illegal      registered, set when the accepted code was 111
module alu_multicycle #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      ALU_control,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   output logic            ready,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_SLT = 3'b101;
   localparam logic [2:0] OP_SLL = 3'b100;
   localparam logic [2:0] OP_SRL = 3'b110;
   localparam logic [2:0] OP_ILL = 3'b111;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t          state, state_nxt;
   logic [XLEN-1:0] acc, acc_nxt;
   logic [4:0]      cnt, cnt_nxt;
   logic            sh_left, sh_left_nxt;
   logic [XLEN-1:0] result_nxt;
   logic            zero_nxt, illegal_nxt, done_nxt;

   logic [XLEN-1:0] alu_res;
   logic [XLEN-1:0] acc_sh;
   logic            is_shift;
   logic [4:0]      shamt;

   assign shamt    = src_b[4:0];
   assign is_shift = (ALU_control == OP_SLL) || (ALU_control == OP_SRL);
   assign ready    = (state == IDLE);

   // One-bit step of the iterative shifter.
   assign acc_sh = sh_left ? {acc[XLEN-2:0], 1'b0} : {1'b0, acc[XLEN-1:1]};

   // Single-cycle result; shifts land here only when shamt is 0.
   always_comb begin
      alu_res = '0;
      case (ALU_control)
         OP_ADD:         alu_res = src_a + src_b;
         OP_SUB:         alu_res = src_a - src_b;
         OP_AND:         alu_res = src_a & src_b;
         OP_OR:          alu_res = src_a | src_b;
         OP_SLT:         alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         OP_SLL, OP_SRL: alu_res = src_a;
         OP_ILL:         alu_res = '0;
         default:        alu_res = '0;
      endcase
   end

   always_comb begin
      state_nxt   = state;
      acc_nxt     = acc;
      cnt_nxt     = cnt;
      sh_left_nxt = sh_left;
      result_nxt  = result;
      zero_nxt    = zero;
      illegal_nxt = illegal;
      done_nxt    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (is_shift && (shamt != 5'd0)) begin
                  acc_nxt     = src_a;
                  cnt_nxt     = shamt;
                  sh_left_nxt = (ALU_control == OP_SLL);
                  state_nxt   = SHIFT;
               end else begin
                  result_nxt  = alu_res;
                  zero_nxt    = (alu_res == '0);
                  illegal_nxt = (ALU_control == OP_ILL);
                  done_nxt    = 1'b1;
               end
            end
         end
         SHIFT: begin
            acc_nxt = acc_sh;
            cnt_nxt = cnt - 5'd1;
            // Last step: the value being shifted in is the final result.
            if (cnt == 5'd1) begin
               result_nxt  = acc_sh;
               zero_nxt    = (acc_sh == '0);
               illegal_nxt = 1'b0;
               done_nxt    = 1'b1;
               state_nxt   = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         acc     <= '0;
         cnt     <= '0;
         sh_left <= 1'b0;
         result  <= '0;
         zero    <= 1'b1;
         illegal <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         acc     <= acc_nxt;
         cnt     <= cnt_nxt;
         sh_left <= sh_left_nxt;
         result  <= result_nxt;
         zero    <= zero_nxt;
         illegal <= illegal_nxt;
         done    <= done_nxt;
      end
   end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed operations push their
// hand-computed response (value, flags, done cycle) into a queue; a monitor
// pops and compares on every done.
module tb_alu_multicycle;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  ALU_control;
   logic [31:0] src_a, src_b;
   logic        ready, done, zero, illegal;
   logic [31:0] result;

   alu_multicycle #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .start(start), .ALU_control(ALU_control),
      .src_a(src_a), .src_b(src_b), .ready(ready), .done(done),
      .result(result), .zero(zero), .illegal(illegal)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      logic        z;
      logic        ill;
      int          at;
   } exp_t;

   exp_t q[$];
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every done must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: actual=done required=no_done (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("result",     result,         e.res);
            check("zero",       {31'b0, zero},  {31'b0, e.z});
            check("illegal",    {31'b0, illegal}, {31'b0, e.ill});
            check("done_cycle", cyc,            e.at);
         end
      end
   end

   // Issue one operation; lat = cycles after the accepting edge's cycle
   // in which done is expected (0 for single-cycle ops, N for shifts).
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_ill, input int lat,
                        input bit expect_done);
      exp_t e;
      int guard;
      @(negedge clk);
      guard = 0;
      while (ready !== 1'b1 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) begin
         n_cmp++;
         n_bad++;
         $display("FAIL ready_timeout: actual=ready_low required=ready_high (cycle %0d)", cyc);
      end
      start = 1'b1; ALU_control = op; src_a = a; src_b = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      e.res = exp_res; e.z = (exp_res == 32'd0); e.ill = exp_ill; e.at = cyc + lat;
      if (expect_done) q.push_back(e);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (q.size() != 0 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check("queue_drained", q.size(), 0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ready"},   {31'b0, ready},   32'd1);
      check({tag, "_done"},    {31'b0, done},    32'd0);
      check({tag, "_result"},  result,           32'd0);
      check({tag, "_zero"},    {31'b0, zero},    32'd1);
      check({tag, "_illegal"}, {31'b0, illegal}, 32'd0);
   endtask

   initial begin
      int low;
      rst = 1'b1; start = 1'b0; ALU_control = 3'b000; src_a = '0; src_b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_vals("reset");
      rst = 1'b0;

      // Single-cycle ops
      issue(3'b000, 32'd5, 32'd7, 32'd12, 1'b0, 0, 1);
      issue(3'b001, 32'd7, 32'd7, 32'd0, 1'b0, 0, 1);
      issue(3'b101, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 0, 1);
      issue(3'b101, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 0, 1);
      issue(3'b010, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0, 0, 1);
      issue(3'b011, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FFF0, 1'b0, 0, 1);
      issue(3'b000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 0, 1);
      issue(3'b001, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 0, 1);

      // sll by 31: ready low for 31 cycles, done in the 32nd
      issue(3'b100, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 31, 1);
      low = 0;
      for (int i = 0; i < 31; i++) begin
         @(negedge clk);
         if (ready === 1'b0) low++;
      end
      check("sll31_ready_low_cycles", low, 31);
      @(negedge clk);
      check("sll31_ready_back", {31'b0, ready}, 32'd1);
      drain();

      issue(3'b110, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 4, 1);
      // shamt 0 via bit 5 set: single-cycle pass-through
      issue(3'b100, 32'h0000_1234, 32'h0000_0020, 32'h0000_1234, 1'b0, 0, 1);
      issue(3'b110, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 0, 1);
      // illegal, then a shift clears the flag
      issue(3'b111, 32'd9, 32'd3, 32'd0, 1'b1, 0, 1);
      issue(3'b100, 32'd3, 32'd2, 32'd12, 1'b0, 2, 1);
      issue(3'b111, 32'd1, 32'd1, 32'd0, 1'b1, 0, 1);
      issue(3'b011, 32'd0, 32'd0, 32'd0, 1'b0, 0, 1);
      drain();

      // start pulsed mid-shift with new operands is ignored
      issue(3'b110, 32'hF000_0000, 32'd8, 32'h00F0_0000, 1'b0, 8, 1);
      @(negedge clk); @(negedge clk);
      start = 1'b1; ALU_control = 3'b000; src_a = 32'd1; src_b = 32'd1;
      @(negedge clk);
      start = 1'b0;
      drain();

      // back-to-back adds
      issue(3'b000, 32'd1, 32'd2, 32'd3, 1'b0, 0, 1);
      issue(3'b000, 32'd10, 32'd20, 32'd30, 1'b0, 0, 1);
      issue(3'b000, 32'd100, 32'd200, 32'd300, 1'b0, 0, 1);
      drain();

      // reset mid 20-bit shift: no done; start held during reset ignored
      issue(3'b100, 32'd1, 32'd20, 32'd0, 1'b0, 20, 0);
      repeat (5) @(negedge clk);
      rst = 1'b1; start = 1'b1; ALU_control = 3'b000; src_a = 32'd3; src_b = 32'd4;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      check_reset_vals("midshift_reset");
      repeat (30) @(negedge clk);
      check("post_reset_ready", {31'b0, ready}, 32'd1);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
